// File: rtl/ivector_ind_serializer.sv
// Buffers method indications in a small FIFO and emits each as a header word plus one payload word.
// Optional macro IVECTOR_IND_SEQ_EN puts a wrapping 8-bit sequence number in header bits [31:24].
module ivector_ind_serializer #(
    parameter int DEPTH      = 4,
    parameter int METH_COUNT = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        heard__ENA,
    input  logic [31:0] heard_meth,
    input  logic [31:0] heard_v,
    output logic        heard__RDY,
    output logic        msg__ENA,
    output logic [31:0] msg_data,
    output logic        msg_last,
    input  logic        msg__RDY,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t          state_reg;
    logic [47:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   rd_ptr_inc;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [7:0]      drop_count_reg;
    logic [7:0]      seq_next;
    logic [31:0]     msg_data_reg;
    logic            msg_last_reg;
    logic            meth_ok;
    logic            push;
    logic            pop;
    logic            drop;
    logic [47:0]     head_entry;
    logic [15:0]     next_meth;

    function automatic logic [31:0] make_hdr(input logic [7:0] seq, input logic [15:0] meth);
        return {seq, 8'd1, meth};
    endfunction

    always_comb begin
        meth_ok    = heard_meth < 32'(METH_COUNT);
        heard__RDY = (count_reg != CW'(DEPTH));
        push       = heard__ENA && heard__RDY && meth_ok;
        drop       = heard__ENA && !meth_ok;
        pop        = (state_reg == PAY) && msg__RDY;
        msg__ENA   = nRST && (state_reg != IDLE) && msg__RDY;
        count_next = count_reg + CW'(push) - CW'(pop);
        rd_ptr_inc = rd_ptr_reg + AW'(1);
        head_entry = mem[rd_ptr_reg];
        // With a single entry left, the next header comes from the entry being accepted this cycle.
        next_meth  = (count_reg > CW'(1)) ? mem[rd_ptr_inc][47:32] : heard_meth[15:0];
    end

`ifdef IVECTOR_IND_SEQ_EN
    logic [7:0] seq_reg;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            seq_reg <= '0;
        end else if (pop) begin
            seq_reg <= seq_reg + 8'd1;
        end
    end

    // A header loaded on the payload edge must already carry the incremented number.
    assign seq_next = pop ? seq_reg + 8'd1 : seq_reg;
`else
    assign seq_next = 8'd0;
`endif

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= {heard_meth[15:0], heard_v};
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            drop_count_reg <= '0;
            msg_data_reg   <= '0;
            msg_last_reg   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            if (drop && (drop_count_reg != 8'd255)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        state_reg    <= HDR;
                        msg_data_reg <= make_hdr(seq_next, head_entry[47:32]);
                        msg_last_reg <= 1'b0;
                    end
                end
                HDR: begin
                    if (msg__RDY) begin
                        state_reg    <= PAY;
                        msg_data_reg <= head_entry[31:0];
                        msg_last_reg <= 1'b1;
                    end
                end
                PAY: begin
                    if (msg__RDY) begin
                        if (count_next != '0) begin
                            state_reg    <= HDR;
                            msg_data_reg <= make_hdr(seq_next, next_meth);
                        end else begin
                            state_reg    <= IDLE;
                            msg_data_reg <= '0;
                        end
                        msg_last_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    msg_data_reg <= '0;
                    msg_last_reg <= 1'b0;
                end
            endcase
        end
    end

    assign msg_data   = msg_data_reg;
    assign msg_last   = msg_last_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: doc/ivector_ind_serializer.md
IVECTOR_IND_SERIALIZER -- requirements
Module: ivector_ind_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the indication buffer depth in entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter METH_COUNT, default 10, giving the number of legal method indices; heard_meth values at or above it are invalid.
REQ-003 One clock, CLK; reset nRST is synchronous and active-low.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 nRST  input  1  synchronous active-low reset.
REQ-006 heard__ENA  input  1  indication strobe; asserted by the upstream vector block only while heard__RDY is high.
REQ-007 heard_meth  input  32  method index of the indication.
REQ-008 heard_v  input  32  indication payload.
REQ-009 heard__RDY  output  1  high when the buffer can accept an entry this cycle.
REQ-010 msg__ENA  output  1  outbound word strobe; a word transfers in every cycle it is high.
REQ-011 msg_data  output  32  outbound word.
REQ-012 msg_last  output  1  high with the final word of a message.
REQ-013 msg__RDY  input  1  downstream can take a word this cycle.
REQ-014 drop_count  output  8  number of invalid-method indications discarded, saturating.

Function
REQ-015 Buffer: DEPTH-entry circular FIFO of {meth[15:0], v[31:0]}, with wrapping read/write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-016 heard__RDY SHALL be (count != DEPTH); it SHALL NOT depend on a same-cycle pop (no full bypass).
REQ-017 On heard__ENA with heard_meth < METH_COUNT, the entry is written and count increments, unless a pop occurs in the same cycle, in which case count is unchanged.
REQ-018 On heard__ENA with heard_meth >= METH_COUNT, no write occurs and drop_count increments, saturating at 255.
REQ-019 FSM states: IDLE, HDR, PAY. IDLE->HDR when count != 0. HDR->PAY on a header transfer. PAY->HDR on a payload transfer if count after the pop != 0; otherwise PAY->IDLE.
REQ-020 msg__ENA = (state==HDR || state==PAY) && msg__RDY; msg_data and msg_last are held stable while msg__RDY is low.
REQ-021 Header word: [31:24]=sequence field (REQ-031), [23:16]=8'd1 (payload word count), [15:0]=meth of the head entry; msg_last=0.
REQ-022 Payload word: v of the head entry; msg_last=1; the FIFO pops on the payload transfer only.
REQ-023 Latency: an entry accepted at edge N into an empty block in IDLE presents its header at cycle N+2; with msg__RDY held high, its payload follows at N+3.
REQ-024 Back-to-back: PAY->HDR with no IDLE bubble, giving a sustained rate of one message per 2 cycles.
REQ-025 Accepting and popping in the same cycle at count==1 leaves count==1; the FSM goes to HDR.
REQ-026 The FIFO preserves arrival order; no reordering by method index.

Reset
REQ-027 On nRST low at an edge: pointers=0, count=0, state=IDLE, drop_count=0, sequence=0.
REQ-028 During and after reset: heard__RDY=1 from the first cycle with nRST high, msg__ENA=0, msg_last=0, msg_data=0 in IDLE.
REQ-029 Reset mid-message SHALL discard the buffered content and the partial message; no payload word without a header is emitted afterwards.
REQ-030 heard__ENA asserted in a reset cycle SHALL be ignored.

Configuration
REQ-031 Macro IVECTOR_IND_SEQ_EN. When defined: header[31:24] carries an 8-bit sequence number that increments on each payload transfer and wraps 255->0. When undefined: header[31:24]=0 and no sequence register exists.

Verification
REQ-032 Single: reset, msg__RDY=1, heard(meth=3, v=0xDEADBEEF) at cycle 0 -> cycle 2 data=0x00010003 last=0; cycle 3 data=0xDEADBEEF last=1.
REQ-033 Fill: msg__RDY=0, 5 valid heards with DEPTH=4 -> heard__RDY low after the 4th; then release -> 4 messages in order, headers 2 cycles apart.
REQ-034 Invalid: heard(meth=10) and heard(meth=0xFFFF) -> no messages, drop_count=2; 300 invalid heards -> drop_count=255.
REQ-035 Stall: drop msg__RDY in the PAY state for 5 cycles -> msg__ENA=0 and data/last held; the payload is sent once after release.
REQ-036 Sequence (macro defined): 257 messages -> header[31:24] runs 0..255 then 0; macro undefined -> always 0.
REQ-037 Reset mid-PAY: nRST low for 1 cycle while 3 entries are queued -> next output is nothing until a new heard; count=0.
